// File: rtl/video_pll_lock_seq_if.sv
// video_pll_lock_seq_if: PLL pins, CSR relock request and status outputs of
// the video PLL lock sequencer. "master" is the sequencer side, "slave" is
// the PLL/CSR/video side.
interface video_pll_lock_seq_if #(
    parameter int MAX_RETRIES = 3
) ();
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic          pll_locked;
    logic          relock_req;
    logic          pll_rst;
    logic          video_rst;
    logic          fault;
    logic [2:0]    seq_state;
    logic [RW-1:0] retry_cnt;
    logic [7:0]    loss_cnt;

    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output video_rst,
        output fault,
        output seq_state,
        output retry_cnt,
        output loss_cnt
    );

    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  video_rst,
        input  fault,
        input  seq_state,
        input  retry_cnt,
        input  loss_cnt
    );
endinterface

// File: rtl/video_pll_lock_seq.sv
// video_pll_lock_seq: reset/lock sequencer for the video pixel-clock PLL.
// Pulses the PLL reset, waits for a debounced lock, releases the video reset,
// retries on lock timeout, latches FAULT when retries run out and re-sequences
// on loss of lock. Define VIDEO_PLL_SEQ_LOSS_CNT_EN to build the saturating
// loss-of-lock counter; otherwise loss_cnt reads as zero.
module video_pll_lock_seq #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                        refclk,
    input  logic                        rst,
    video_pll_lock_seq_if.master        bus
);
    localparam int MAX_AB = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAXP   = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W  = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam int RW     = $clog2(MAX_RETRIES + 1);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABILIZE = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic             sync1_q, locked_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             video_rst_q, video_rst_d;
    logic             fault_q, fault_d;

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            locked_s_q  <= 1'b0;
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            video_rst_q <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= bus.pll_locked;
            locked_s_q  <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            video_rst_q <= video_rst_d;
            fault_q     <= fault_d;
        end
    end

    // Next state: timed phases on the shared counter, relock request overrides all
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = S_STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RW'(MAX_RETRIES)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_RESET_PLL;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_STABILIZE: begin
                // A dropout restarts the timeout window without costing a retry
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s_q) begin
                    state_d = S_RESET_PLL;
                end
            end
            S_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
        if (bus.relock_req) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // Outputs decoded from the next state so they change on the transition edge
    always_comb begin
        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        video_rst_d = (state_d != S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.video_rst = video_rst_q;
    assign bus.fault     = fault_q;
    assign bus.seq_state = state_q;
    assign bus.retry_cnt = retry_q;

`ifdef VIDEO_PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_q, loss_d;

    // Saturating count of lock losses seen in RUN; relock requests do not clear it
    always_comb begin
        loss_d = loss_q;
        if ((state_q == S_RUN) && !locked_s_q && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
    end

    // Loss counter register, cleared only by rst
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign bus.loss_cnt = loss_q;
`else
    assign bus.loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_video_pll_lock_seq.sv
// tb_video_pll_lock_seq: directed + randomized bench for video_pll_lock_seq
// with a deadline-based reference model of the sequencing rules.
module tb_video_pll_lock_seq;
    localparam int R = 4;
    localparam int L = 8;
    localparam int T = 32;
    localparam int M = 2;
    localparam int MRESET = 0, MWAIT = 1, MSTAB = 2, MRUN = 3, MFAULT = 4;

    logic refclk = 1'b0;
    logic rst;

    video_pll_lock_seq_if #(.MAX_RETRIES(M)) bus ();

    video_pll_lock_seq #(
        .RST_CYCLES(R), .LOCK_STABLE_CYCLES(L),
        .LOCK_TIMEOUT_CYCLES(T), .MAX_RETRIES(M)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .bus(bus)
    );

    always #10 refclk = ~refclk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: phase plus the cycle number at which it was entered
    int unsigned cyc = 0;
    int unsigned m_entry = 0;
    int m_mode = MRESET;
    int m_retries = 0;
    int m_loss = 0;
    bit m_sa = 1'b0;
    bit m_sb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic enter(input int mode);
        m_mode  = mode;
        m_entry = cyc;
    endtask

    task automatic model_edge();
        int unsigned el;
        bit ls;
        bit loss;
        cyc++;
        if (rst) begin
            enter(MRESET);
            m_retries = 0;
            m_loss    = 0;
            m_sa      = 1'b0;
            m_sb      = 1'b0;
        end else begin
            ls   = m_sb;
            el   = cyc - m_entry;
            loss = (m_mode == MRUN) && !ls;
            if (bus.relock_req) begin
                enter(MRESET);
                m_retries = 0;
            end else begin
                case (m_mode)
                    MRESET: if (el == R) enter(MWAIT);
                    MWAIT: begin
                        if (ls) enter(MSTAB);
                        else if (el == T) begin
                            if (m_retries < M) begin
                                m_retries++;
                                enter(MRESET);
                            end else begin
                                enter(MFAULT);
                            end
                        end
                    end
                    MSTAB: begin
                        if (!ls) enter(MWAIT);
                        else if (el == L) begin
                            enter(MRUN);
                            m_retries = 0;
                        end
                    end
                    MRUN: if (!ls) enter(MRESET);
                    default: ;
                endcase
            end
            if (loss && m_loss < 255) m_loss++;
            m_sb = m_sa;
            m_sa = bus.pll_locked;
        end
    endtask

    task automatic compare_all();
        int exp_loss;
`ifdef VIDEO_PLL_SEQ_LOSS_CNT_EN
        exp_loss = m_loss;
`else
        exp_loss = 0;
`endif
        chk("pll_rst", 32'(bus.pll_rst), 32'((m_mode == MRESET) || (m_mode == MFAULT)));
        chk("video_rst", 32'(bus.video_rst), 32'(m_mode != MRUN));
        chk("fault", 32'(bus.fault), 32'(m_mode == MFAULT));
        chk("seq_state", 32'(bus.seq_state), m_mode);
        chk("retry_cnt", 32'(bus.retry_cnt), m_retries);
        chk("loss_cnt", 32'(bus.loss_cnt), exp_loss);
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int k = 0;
        while (32'(bus.seq_state) != target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(bus.seq_state), target);
    endtask

    int cnt_hi;
    int rel;
    int nlow;
    int exp_loss1;
    int exp_loss_sat;

    initial begin
`ifdef VIDEO_PLL_SEQ_LOSS_CNT_EN
        exp_loss1    = 1;
        exp_loss_sat = 255;
`else
        exp_loss1    = 0;
        exp_loss_sat = 0;
`endif
        // Reset values
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_pll_rst", 32'(bus.pll_rst), 1);
        chk("rst_video_rst", 32'(bus.video_rst), 1);
        chk("rst_seq_state", 32'(bus.seq_state), 0);

        // Power-up, clean lock 10 cycles after release
        rst = 1'b0;
        cnt_hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.pll_rst) cnt_hi++;
            tick();
        end
        chk("pwr_pll_rst_width", cnt_hi, R);
        bus.pll_locked = 1'b1;
        rel = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rel == 0 && bus.video_rst == 1'b0) rel = k;
        end
        chk("pwr_release_edge", rel, L + 3);
        chk("pwr_state_run", 32'(bus.seq_state), MRUN);
        chk("pwr_retry_zero", 32'(bus.retry_cnt), 0);

        // Stability glitch: 3-cycle dropout during STABILIZE
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        wait_state(MSTAB, 40, "glitch_reach_stab");
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
        bus.pll_locked = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        bus.pll_locked = 1'b1;
        rel = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rel == 0 && bus.video_rst == 1'b0) rel = k;
        end
        chk("glitch_release_edge", rel, L + 3);

        // Loss in RUN, then timeouts until FAULT
        bus.pll_locked = 1'b0;
        rel = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (rel == 0 && bus.video_rst == 1'b1) rel = k;
        end
        chk("loss_video_rst_edge", rel, 3);
        chk("loss_cnt_first", 32'(bus.loss_cnt), exp_loss1);
        wait_state(MFAULT, 200, "reach_fault");
        chk("fault_flag", 32'(bus.fault), 1);
        chk("fault_pll_rst", 32'(bus.pll_rst), 1);
        chk("fault_retry", 32'(bus.retry_cnt), M);
        for (int k = 0; k < 5; k++) tick();

        // Relock from FAULT
        bus.pll_locked = 1'b1;
        tick();
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        chk("relock_fault_clear", 32'(bus.fault), 0);
        cnt_hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.pll_rst) break;
            cnt_hi++;
            tick();
        end
        chk("relock_pll_rst_width", cnt_hi, R);
        wait_state(MRUN, 40, "relock_reach_run");

        // Repeated losses in RUN, some with a relock request mixed in
        for (int i = 0; i < 300; i++) begin
            bus.pll_locked = 1'b0;
            nlow = int'($urandom_range(1, 3));
            for (int k = 0; k < nlow; k++) tick();
            if ($urandom_range(0, 7) == 0) begin
                bus.relock_req = 1'b1;
                tick();
                bus.relock_req = 1'b0;
            end
            bus.pll_locked = 1'b1;
            tick();
            tick();
            wait_state(MRUN, 60, "loss_loop_run");
        end
        chk("loss_cnt_saturated", 32'(bus.loss_cnt), exp_loss_sat);

        // Mid-sequence reset together with relock_req
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        wait_state(MSTAB, 40, "midrst_reach_stab");
        rst = 1'b1;
        bus.relock_req = 1'b1;
        tick();
        rst = 1'b0;
        bus.relock_req = 1'b0;
        chk("midrst_pll_rst", 32'(bus.pll_rst), 1);
        chk("midrst_video_rst", 32'(bus.video_rst), 1);
        chk("midrst_fault", 32'(bus.fault), 0);
        chk("midrst_seq_state", 32'(bus.seq_state), 0);
        chk("midrst_retry", 32'(bus.retry_cnt), 0);
        chk("midrst_loss", 32'(bus.loss_cnt), 0);

        // Random soak against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) bus.pll_locked = ~bus.pll_locked;
            if ($urandom_range(0, 199) == 0) bus.pll_locked = 1'b0;
            bus.relock_req = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        bus.relock_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
